sim_run_ctrl: RTL

Test-run sequencer for the pd5 core bench. It sits between the bench clock/reset generator and the core, and does four things:
- stretches bench reset into a core reset;
- counts cycles and retired instructions;
- detects program end (ecall or a jump-to-self) and lets the pipeline drain;
- reports done/pass/cause, enforcing a cycle timeout as a watchdog.

---
 rtl/sim_run_ctrl_pkg.sv | 18 +
 rtl/sim_run_ctrl_sat_counter.sv | 20 ++
 rtl/sim_run_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sim_run_ctrl_pkg.sv
// sim_run_ctrl_pkg: shared states, end causes and halt encodings for sim_run_ctrl
package sim_run_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } run_state_e;
    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_ECALL    = 3'd1,
        CAUSE_SELFLOOP = 3'd2,
        CAUSE_TIMEOUT  = 3'd3,
        CAUSE_STALL    = 3'd4
    } run_cause_e;
    localparam logic [31:0] INSN_ECALL    = 32'h0000_0073;
    localparam logic [31:0] INSN_SELFLOOP = 32'h0000_006F;
endpackage

// File: rtl/sim_run_ctrl_sat_counter.sv
// sat_counter: W-bit up counter with clear that sticks at all-ones instead of wrapping
module sat_counter
    import sim_run_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: pd5 bench run sequencer; SIM_RUN_CTRL_STALL_WDT_EN adds a no-retire stall watchdog
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 5,
    parameter int TIMEOUT      = 100000,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32,
    parameter int STALL_LIMIT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    input  logic [31:0]      retire_insn,
    input  logic [31:0]      exit_code,
    output logic             core_rst,
    output logic             run,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic             done,
    output logic             pass,
    output logic [2:0]       cause
);
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("sim_run_ctrl: RESET_CYCLES must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sim_run_ctrl: TIMEOUT must be >= 1");
    end
    if (STALL_LIMIT < 1) begin : g_bad_stall_limit
        $error("sim_run_ctrl: STALL_LIMIT must be >= 1");
    end

    localparam logic [31:0]      RST_LAST   = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LAST = 32'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

    run_state_e  state_q, state_d;
    run_cause_e  cause_q, cause_d;
    logic [31:0] phase_q, phase_d, exit_q, exit_d;
    logic        core_rst_q, core_rst_d, run_q, run_d, done_q, done_d, pass_q, pass_d;
    logic        in_run, halt, timeout_hit, stall_hit, cyc_inc, unused_pc;

    assign in_run      = state_q == ST_RUN;
    assign halt        = in_run && retire_valid &&
                         (retire_insn == INSN_ECALL || retire_insn == INSN_SELFLOOP);
    assign timeout_hit = in_run && cycle_count == TO_LAST;
    // A halt edge still counts its cycle; a watchdog exit freezes the count at the limit.
    assign cyc_inc     = in_run && (halt || !(timeout_hit || stall_hit));
    assign unused_pc   = ^retire_pc;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (cyc_inc),
        .cnt_o (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (in_run && retire_valid),
        .cnt_o (instr_count)
    );

`ifdef SIM_RUN_CTRL_STALL_WDT_EN
    logic [CNT_W-1:0] stall_cnt;
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (in_run && retire_valid),
        .inc_i (in_run && !retire_valid),
        .cnt_o (stall_cnt)
    );
    assign stall_hit = in_run && !retire_valid && stall_cnt == CNT_W'(STALL_LIMIT - 1);
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        exit_d     = exit_q;
        cause_d    = cause_q;
        core_rst_d = core_rst_q;
        run_d      = run_q;
        done_d     = done_q;
        pass_d     = pass_q;
        case (state_q)
            ST_RST_HOLD: begin
                phase_d = phase_q + 32'd1;
                if (phase_q == RST_LAST) begin
                    state_d    = ST_RUN;
                    phase_d    = '0;
                    core_rst_d = 1'b0;
                    run_d      = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_DRAIN;
                    phase_d = '0;
                    exit_d  = exit_code;
                    cause_d = (retire_insn == INSN_ECALL) ? CAUSE_ECALL : CAUSE_SELFLOOP;
                    run_d   = 1'b0;
                end else if (timeout_hit || stall_hit) begin
                    state_d = ST_DONE;
                    cause_d = timeout_hit ? CAUSE_TIMEOUT : CAUSE_STALL;
                    run_d   = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            ST_DRAIN: begin
                phase_d = phase_q + 32'd1;
                if (phase_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = exit_q == '0;
                end
            end
            ST_DONE: ;
            default: begin
                state_d    = ST_RST_HOLD;
                phase_d    = '0;
                cause_d    = CAUSE_NONE;
                core_rst_d = 1'b1;
                run_d      = 1'b0;
                done_d     = 1'b0;
                pass_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RST_HOLD;
            phase_q    <= '0;
            exit_q     <= '0;
            cause_q    <= CAUSE_NONE;
            core_rst_q <= 1'b1;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            exit_q     <= exit_d;
            cause_q    <= cause_d;
            core_rst_q <= core_rst_d;
            run_q      <= run_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign core_rst = core_rst_q;
    assign run      = run_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign cause    = cause_q;
endmodule
